sm_add_sched: RTL

Round-robin scheduler that shares one 32-bit sign-magnitude adder among `N_REQ` requesters in the ZF detector datapath, for example the matrix-inverse and equalizer partial-sum paths. It grants one operand pair per cycle and registers the operands into a 2-stage pipeline. It returns each sum with the originating requester ID over a valid/ready result port, which carries backpressure.

---
 rtl/zf_pkg.sv | 14 +
 rtl/sm_add32.sv | 33 +++
 rtl/sm_add_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/zf_pkg.sv
// Shared ZF detector datapath types.
// Sign-magnitude word layout used by the partial-sum adders.
package zf_pkg;

    localparam int SM_W     = 32;
    localparam int SM_SIGN  = 31;
    localparam int SM_MAG_W = 31;

    typedef struct packed {
        logic                sign;
        logic [SM_MAG_W-1:0] mag;
    } sm32_t;

endpackage

// File: rtl/sm_add32.sv
// Combinational 32-bit sign-magnitude adder.
// Negative zero is passed through unnormalized.
module sm_add32
    import zf_pkg::*;
(
    input  logic [SM_W-1:0] a,
    input  logic [SM_W-1:0] b,
    output logic [SM_W-1:0] sum,
    output logic            ovf
);

    sm32_t             w_a;
    sm32_t             w_b;
    logic [SM_MAG_W:0] w_mag_sum;

    assign w_a       = sm32_t'(a);
    assign w_b       = sm32_t'(b);
    assign w_mag_sum = {1'b0, w_a.mag} + {1'b0, w_b.mag};

    always_comb begin
        sum = '0;
        ovf = 1'b0;
        if (w_a.sign == w_b.sign) begin
            sum = {w_a.sign, w_mag_sum[SM_MAG_W-1:0]};
            ovf = w_mag_sum[SM_MAG_W];
        end else if (w_a.mag > w_b.mag) begin
            sum = {w_a.sign, w_a.mag - w_b.mag};
        end else if (w_b.mag > w_a.mag) begin
            sum = {w_b.sign, w_b.mag - w_a.mag};
        end
    end

endmodule

// File: rtl/sm_add_sched.sv
// Round-robin scheduler sharing one sign-magnitude adder among N_REQ
// requesters, with a 2-stage operand/result pipeline and result backpressure.
module sm_add_sched
    import zf_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*SM_W-1:0] req_a,
    input  logic [N_REQ*SM_W-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [SM_W-1:0]       res_data,
    output logic [ID_W-1:0]       res_id,
    output logic                  res_ovf
);

    logic [ID_W-1:0] r_ptr;
    logic            r_s1_valid;
    logic [SM_W-1:0] r_op_a;
    logic [SM_W-1:0] r_op_b;
    logic [ID_W-1:0] r_op_id;
    logic            r_res_valid;
    logic [SM_W-1:0] r_res_data;
    logic [ID_W-1:0] r_res_id;
    logic            r_res_ovf;

    logic            w_s2_adv;
    logic            w_s1_adv;
    logic            w_found;
    logic [ID_W-1:0] w_gnt_id;
    logic [ID_W-1:0] w_ptr_nxt;
    logic            w_xfer;
    logic [SM_W-1:0] w_gnt_a;
    logic [SM_W-1:0] w_gnt_b;
    logic [SM_W-1:0] w_sum;
    logic            w_ovf;

    assign w_s2_adv = !r_res_valid || res_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    // First valid requester at or after r_ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(r_ptr) + k) % N_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_gnt_id = ID_W'(idx);
            end
        end
    end

    assign w_xfer    = w_found && w_s1_adv && !rst;
    assign req_ready = w_xfer ? (N_REQ'(1) << w_gnt_id) : '0;
    assign w_gnt_a   = req_a[int'(w_gnt_id)*SM_W +: SM_W];
    assign w_gnt_b   = req_b[int'(w_gnt_id)*SM_W +: SM_W];
    assign w_ptr_nxt = (int'(w_gnt_id) == N_REQ - 1) ? '0
                                                      : w_gnt_id + ID_W'(1);

    sm_add32 u_add (
        .a   (r_op_a),
        .b   (r_op_b),
        .sum (w_sum),
        .ovf (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_s1_valid  <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_id     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_res_ovf   <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_ptr <= w_ptr_nxt;
            end
            if (w_s1_adv) begin
                r_s1_valid <= w_xfer;
                if (w_xfer) begin
                    r_op_a  <= w_gnt_a;
                    r_op_b  <= w_gnt_b;
                    r_op_id <= w_gnt_id;
                end
            end
            if (w_s2_adv) begin
                r_res_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_res_data <= w_sum;
                    r_res_id   <= r_op_id;
                    r_res_ovf  <= w_ovf;
                end
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign res_ovf   = r_res_ovf;

endmodule
